pkt_5tuple_parser: RTL
======================

PKT_5TUPLE_PARSER -- requirements
Module: pkt_5tuple_parser

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 512: packet bus width; only 512 is supported.
REQ-002 The block SHALL have parameter CNT_WIDTH, default 32: width of each statistics counter.
REQ-003 Port clk, input, 1: single clock; all logic SHALL be on its rising edge.
REQ-004 Port reset, input, 1: synchronous, active-high reset.
REQ-005 Port in_pkt_ctl, input, 8: beat code: 0x00 invalid, 0x01 start, 0x02 payload, 0x03 end, 0x04 single-beat 64-byte packet; 0x05-0xFF illegal.
REQ-006 Port in_pkt_data, input, DATA_WIDTH: beat data; byte 0 of the beat SHALL be bits [511:504], byte n at [511-8n -: 8].
REQ-007 Port out_valid_5tuple, output, 1: one-cycle strobe qualifying out_5tuple.
REQ-008 Port out_5tuple, output, 104: {src_ip[31:0], dst_ip[31:0], src_port[15:0], dst_port[15:0], proto[7:0]}.
REQ-009 Port out_valid_sqn, output, 1: one-cycle strobe qualifying out_sqn; only asserted for TCP.
REQ-010 Port out_sqn, output, 32: TCP sequence number.
REQ-011 Ports stat_pkt_cnt, stat_drop_cnt, stat_err_cnt, output, CNT_WIDTH each: accepted packets, dropped (non-IPv4/TCP/UDP) packets, framing errors.

Function
REQ-012 Header fields SHALL be taken from the first beat only (code 0x01 or 0x04): ethertype bytes 12-13, ver/IHL byte 14, proto byte 23, src_ip 26-29, dst_ip 30-33, src_port 34-35, dst_port 36-37, sqn 38-41, all big-endian.
REQ-013 A packet SHALL be eligible only if ethertype==0x0800, ver/IHL byte==0x45, and proto is 0x06 (TCP) or 0x11 (UDP); otherwise it is counted in stat_drop_cnt at its end beat and emits nothing.
REQ-014 FSM states SHALL be IDLE and IN_PKT; reset state is IDLE.
REQ-015 IDLE: 0x01 captures header into a holding register and moves to IN_PKT; 0x04 captures and completes the packet in the same cycle, staying in IDLE; 0x00 no action; 0x02/0x03/illegal increment stat_err_cnt and are ignored.
REQ-016 IN_PKT: 0x02 and 0x00 stay in IN_PKT; 0x03 completes the held packet and returns to IDLE.
REQ-017 IN_PKT, 0x01: held packet SHALL be aborted (no output, stat_err_cnt+1), new header captured, remain in IN_PKT.
REQ-018 IN_PKT, 0x04: held packet aborted (stat_err_cnt+1), the 0x04 packet completed normally, go to IDLE.
REQ-019 IN_PKT, illegal code: stat_err_cnt+1, held packet aborted, go to IDLE.
REQ-020 On completion of an eligible packet, out_valid_5tuple SHALL assert exactly one cycle, in the cycle after the completing beat (latency 1), with out_5tuple from that packet's first beat; stat_pkt_cnt+1.
REQ-021 For TCP, out_valid_sqn SHALL assert in the same cycle as out_valid_5tuple with out_sqn; for UDP out_valid_sqn=0 and out_sqn=0.
REQ-022 When strobes are low, out_5tuple and out_sqn SHALL be 0.
REQ-023 Back-to-back 0x04 beats SHALL each produce a strobe on consecutive cycles; throughput one packet per cycle, no backpressure.
REQ-024 Counters SHALL saturate at all-ones, not wrap; at most one increment per counter per cycle (framing error and completion in the same cycle update different counters).
REQ-025 in_pkt_data SHALL be ignored on 0x00, 0x02, 0x03 beats.

Reset
REQ-026 While reset is high: FSM to IDLE, holding register cleared, all outputs and counters 0.
REQ-027 Reset asserted mid-packet SHALL discard the held packet without counting it; subsequent 0x02/0x03 beats after reset release count as framing errors.

Verification
REQ-028 TCP 0x04 beat, src 10.0.0.1, dst 10.0.0.2, ports 0x1234/0x0050, sqn 0xBBBB1111 -> next cycle out_5tuple=0x0A000001_0A000002_1234_0050_06, out_sqn=0xBBBB1111, both strobes 1, stat_pkt_cnt=1.
REQ-029 UDP packet 0x01,0x02,0x00,0x03 -> single out_valid_5tuple one cycle after 0x03, proto 0x11, out_valid_sqn=0.
REQ-030 ARP (ethertype 0x0806) 0x04 beat -> no strobes, stat_drop_cnt=1.
REQ-031 0x01 then 0x01 (TCP, sqn 0xBBBB2222) then 0x03 -> one output with sqn 0xBBBB2222, stat_err_cnt=1.
REQ-032 0x03 in IDLE, then reset during 0x01..0x02 packet -> stat_err_cnt=1 before reset, all counters 0 and no output after.
REQ-033 Three consecutive TCP 0x04 beats -> three strobes on three consecutive cycles, stat_pkt_cnt=3.

Source files
------------

// File: rtl/pkt_5tuple_parser.sv
// Ethernet/IPv4 5-tuple extractor: takes header fields from a packet's first beat
// and emits a registered 5-tuple (plus the TCP sequence number) when the packet completes.
module pkt_5tuple_parser #(
  parameter int DATA_WIDTH = 512,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_pkt_ctl,
  input  logic [DATA_WIDTH-1:0] in_pkt_data,
  output logic                  out_valid_5tuple,
  output logic [103:0]          out_5tuple,
  output logic                  out_valid_sqn,
  output logic [31:0]           out_sqn,
  output logic [CNT_WIDTH-1:0]  stat_pkt_cnt,
  output logic [CNT_WIDTH-1:0]  stat_drop_cnt,
  output logic [CNT_WIDTH-1:0]  stat_err_cnt
);

  typedef enum logic {IDLE, IN_PKT} state_e;

  typedef struct packed {
    logic [103:0] tuple;
    logic [31:0]  sqn;
    logic         eligible;
    logic         is_tcp;
  } hdr_t;

  localparam logic [7:0] CTL_INVALID = 8'h00;
  localparam logic [7:0] CTL_START   = 8'h01;
  localparam logic [7:0] CTL_PAYLOAD = 8'h02;
  localparam logic [7:0] CTL_END     = 8'h03;
  localparam logic [7:0] CTL_SINGLE  = 8'h04;
  localparam logic [7:0] PROTO_TCP   = 8'h06;
  localparam logic [7:0] PROTO_UDP   = 8'h11;

  // Byte 0 of a beat sits in the most significant byte lane.
  function automatic logic [7:0] byte_at(input logic [DATA_WIDTH-1:0] d, input int n);
    return d[DATA_WIDTH-1-8*n -: 8];
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] q, input logic en);
    return (en && (q != '1)) ? q + CNT_WIDTH'(1) : q;
  endfunction

  state_e               state_q, state_d;
  hdr_t                 hold_q, hold_d;
  hdr_t                 fresh_hdr, done_hdr;
  logic                 done, err;
  logic                 out_valid_5tuple_q, out_valid_sqn_q;
  logic [103:0]         out_5tuple_q;
  logic [31:0]          out_sqn_q;
  logic [CNT_WIDTH-1:0] stat_pkt_cnt_q, stat_drop_cnt_q, stat_err_cnt_q;
  logic [15:0]          ethertype;
  logic [7:0]           ver_ihl, proto;
  logic                 unused_data;

  // Only the header bytes are decoded; the rest of the beat is intentionally dropped.
  assign unused_data = ^in_pkt_data;

  always_comb begin
    ethertype          = {byte_at(in_pkt_data, 12), byte_at(in_pkt_data, 13)};
    ver_ihl            = byte_at(in_pkt_data, 14);
    proto              = byte_at(in_pkt_data, 23);
    fresh_hdr.tuple    = {byte_at(in_pkt_data, 26), byte_at(in_pkt_data, 27),
                          byte_at(in_pkt_data, 28), byte_at(in_pkt_data, 29),
                          byte_at(in_pkt_data, 30), byte_at(in_pkt_data, 31),
                          byte_at(in_pkt_data, 32), byte_at(in_pkt_data, 33),
                          byte_at(in_pkt_data, 34), byte_at(in_pkt_data, 35),
                          byte_at(in_pkt_data, 36), byte_at(in_pkt_data, 37), proto};
    fresh_hdr.sqn      = {byte_at(in_pkt_data, 38), byte_at(in_pkt_data, 39),
                          byte_at(in_pkt_data, 40), byte_at(in_pkt_data, 41)};
    fresh_hdr.eligible = (ethertype == 16'h0800) && (ver_ihl == 8'h45) &&
                         ((proto == PROTO_TCP) || (proto == PROTO_UDP));
    fresh_hdr.is_tcp   = (proto == PROTO_TCP);
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    hold_d   = hold_q;
    done     = 1'b0;
    done_hdr = hold_q;
    err      = 1'b0;
    unique case (state_q)
      IDLE: begin
        case (in_pkt_ctl)
          CTL_INVALID: ;
          CTL_START: begin
            hold_d  = fresh_hdr;
            state_d = IN_PKT;
          end
          CTL_SINGLE: begin
            done     = 1'b1;
            done_hdr = fresh_hdr;
          end
          default: err = 1'b1;
        endcase
      end
      IN_PKT: begin
        case (in_pkt_ctl)
          CTL_INVALID, CTL_PAYLOAD: ;
          CTL_END: begin
            done    = 1'b1;
            state_d = IDLE;
          end
          CTL_START: begin
            err    = 1'b1;
            hold_d = fresh_hdr;
          end
          CTL_SINGLE: begin
            err      = 1'b1;
            done     = 1'b1;
            done_hdr = fresh_hdr;
            state_d  = IDLE;
          end
          default: begin
            err     = 1'b1;
            state_d = IDLE;
          end
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q            <= IDLE;
      hold_q             <= '0;
      out_valid_5tuple_q <= 1'b0;
      out_5tuple_q       <= '0;
      out_valid_sqn_q    <= 1'b0;
      out_sqn_q          <= '0;
      stat_pkt_cnt_q     <= '0;
      stat_drop_cnt_q    <= '0;
      stat_err_cnt_q     <= '0;
    end else begin
      state_q            <= state_d;
      hold_q             <= hold_d;
      out_valid_5tuple_q <= done && done_hdr.eligible;
      out_5tuple_q       <= (done && done_hdr.eligible) ? done_hdr.tuple : '0;
      out_valid_sqn_q    <= done && done_hdr.eligible && done_hdr.is_tcp;
      out_sqn_q          <= (done && done_hdr.eligible && done_hdr.is_tcp) ? done_hdr.sqn : '0;
      stat_pkt_cnt_q     <= sat_inc(stat_pkt_cnt_q, done && done_hdr.eligible);
      stat_drop_cnt_q    <= sat_inc(stat_drop_cnt_q, done && !done_hdr.eligible);
      stat_err_cnt_q     <= sat_inc(stat_err_cnt_q, err);
    end
  end

  assign out_valid_5tuple = out_valid_5tuple_q;
  assign out_5tuple       = out_5tuple_q;
  assign out_valid_sqn    = out_valid_sqn_q;
  assign out_sqn          = out_sqn_q;
  assign stat_pkt_cnt     = stat_pkt_cnt_q;
  assign stat_drop_cnt    = stat_drop_cnt_q;
  assign stat_err_cnt     = stat_err_cnt_q;

endmodule
